// File: rtl/delay_timer.sv
// Programmable delay/interval generator: loadable tick count, clock prescaler,
// one-shot or auto-reload, retrigger/abort; done pulses the cycle after expiry.
module delay_timer #(
    parameter int CNT_W         = 24,
    parameter int PRESCALE      = 1,
    parameter int DEFAULT_DELAY = 200000,
    parameter int RETRIGGER     = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             use_default,
    input  logic [CNT_W-1:0] delay_value,
    input  logic             periodic,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] len_q;
    logic [PW-1:0]    presc_q;
    logic             mode_q;
    logic             done_q;
    logic             busy_q;

    logic [CNT_W-1:0] load_d;
    logic             tick_d;
    logic             accept_d;

    always_comb begin
        load_d = use_default ? CNT_W'(DEFAULT_DELAY) : delay_value;
        // A zero-length request still waits one tick.
        if (load_d == '0) begin
            load_d = CNT_W'(1);
        end
        tick_d   = (state_q == RUN) && (presc_q == PRESC_MAX);
        accept_d = start && !abort && ((state_q == IDLE) || (RETRIGGER != 0));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            len_q       <= '0;
            presc_q     <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == RUN) && abort) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                remaining_q <= '0;
                presc_q     <= '0;
            end else begin
                if (tick_d) begin
                    presc_q <= '0;
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                    end else begin
                        done_q <= 1'b1;
                        if (!mode_q) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            remaining_q <= '0;
                        end else begin
                            remaining_q <= len_q;
                        end
                    end
                end else if (state_q == RUN) begin
                    presc_q <= presc_q + PW'(1);
                end
                // A retrigger on the expiry edge keeps the done pulse above.
                if (accept_d) begin
                    state_q     <= RUN;
                    busy_q      <= 1'b1;
                    remaining_q <= load_d;
                    presc_q     <= '0;
                    len_q       <= load_d;
                    mode_q      <= periodic;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: three configurations, done pulses checked against a
// queue of expected edge numbers, status outputs checked at directed points.
module tb_delay_timer;

    localparam int W = 24;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start_v   [3];
    logic         usedef_v  [3];
    logic [W-1:0] dval_v    [3];
    logic         per_v     [3];
    logic         abort_v   [3];
    logic         busy_v    [3];
    logic         done_v    [3];
    logic [W-1:0] rem_v     [3];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int qa[$];
    int qb[$];
    int qc[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    delay_timer #(.CNT_W(W), .PRESCALE(1), .DEFAULT_DELAY(200000), .RETRIGGER(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .use_default(usedef_v[0]),
        .delay_value(dval_v[0]), .periodic(per_v[0]), .abort(abort_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .remaining(rem_v[0]));

    delay_timer #(.CNT_W(W), .PRESCALE(4), .DEFAULT_DELAY(3), .RETRIGGER(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .use_default(usedef_v[1]),
        .delay_value(dval_v[1]), .periodic(per_v[1]), .abort(abort_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .remaining(rem_v[1]));

    delay_timer #(.CNT_W(W), .PRESCALE(1), .DEFAULT_DELAY(200000), .RETRIGGER(0)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .use_default(usedef_v[2]),
        .delay_value(dval_v[2]), .periodic(per_v[2]), .abort(abort_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .remaining(rem_v[2]));

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: each done pulse must match the next expected edge for that unit.
    task automatic mon_pop(input int i);
        int exp;
        exp = -1;
        case (i)
            0: if (qa.size() != 0) exp = qa.pop_front();
            1: if (qb.size() != 0) exp = qb.pop_front();
            default: if (qc.size() != 0) exp = qc.pop_front();
        endcase
        chk($sformatf("done_edge[%0d]", i), cyc, exp);
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] === 1'b1) mon_pop(i);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; start is sampled on the next edge, returned as e0.
    task automatic start_at(input int i, input logic ud, input int val, input logic per,
                            output int e0);
        e0 = cyc + 1;
        start_v[i]  = 1'b1;
        usedef_v[i] = ud;
        dval_v[i]   = W'(val);
        per_v[i]    = per;
        @(negedge clock);
        start_v[i]  = 1'b0;
        usedef_v[i] = 1'b0;
        dval_v[i]   = '0;
        per_v[i]    = 1'b0;
    endtask

    task automatic chk_idle(input string name, input int i);
        chk({name, "_busy"}, busy_v[i], 0);
        chk({name, "_done"}, done_v[i], 0);
        chk({name, "_rem"}, rem_v[i], 0);
    endtask

    int e0, e1;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b1; usedef_v[i] = 1'b0; dval_v[i] = W'(7);
            per_v[i] = 1'b0; abort_v[i] = 1'b0;
        end

        // Reset held with start asserted
        repeat (3) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) chk_idle("reset", i);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) chk_idle("post_reset", i);
        while (cyc < 9) tick(1);

        // One-shot, L=5
        start_at(0, 1'b0, 5, 1'b0, e0);
        qa.push_back(e0 + 5);
        for (int k = 0; k < 5; k++) begin
            chk("oneshot_rem", rem_v[0], 5 - k);
            chk("oneshot_busy", busy_v[0], 1);
            tick(1);
        end
        chk("oneshot_busy_fall", busy_v[0], 0);
        chk("oneshot_rem_end", rem_v[0], 0);
        tick(3);

        // Default length with prescale 4, then L=0
        start_at(1, 1'b1, 9, 1'b0, e0);
        qb.push_back(e0 + 12);
        tick(4);
        chk("presc_rem_after_tick", rem_v[1], 2);
        tick(10);
        start_at(1, 1'b0, 0, 1'b0, e0);
        qb.push_back(e0 + 4);
        tick(3);
        chk("zero_len_busy", busy_v[1], 1);
        chk("zero_len_rem", rem_v[1], 1);
        tick(3);

        // Periodic L=4 with abort sampled at e0+10
        start_at(0, 1'b0, 4, 1'b1, e0);
        qa.push_back(e0 + 4);
        qa.push_back(e0 + 8);
        tick(9);
        chk("periodic_rem_reload", rem_v[0], 3);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        chk("periodic_abort_busy", busy_v[0], 0);
        tick(1);
        chk_idle("periodic_after_abort", 0);
        tick(4);

        // Retrigger enabled
        start_at(0, 1'b0, 10, 1'b0, e0);
        tick(5);
        start_at(0, 1'b0, 3, 1'b0, e1);
        qa.push_back(e1 + 3);
        chk("retrig_rem", rem_v[0], 3);
        tick(6);

        // Retrigger disabled: second start ignored
        start_at(2, 1'b0, 10, 1'b0, e0);
        qc.push_back(e0 + 10);
        tick(5);
        start_at(2, 1'b0, 3, 1'b0, e1);
        chk("noretrig_rem", rem_v[2], 4);
        tick(7);

        // Abort coinciding with expiry
        start_at(0, 1'b0, 3, 1'b0, e0);
        tick(2);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        chk_idle("abort_expiry", 0);
        tick(3);

        // Start coinciding with one-shot expiry
        start_at(0, 1'b0, 3, 1'b0, e0);
        qa.push_back(e0 + 3);
        tick(2);
        start_at(0, 1'b0, 2, 1'b0, e1);
        qa.push_back(e1 + 2);
        chk("start_expiry_busy", busy_v[0], 1);
        chk("start_expiry_rem", rem_v[0], 2);
        tick(4);

        // Periodic L=1: done held high until abort
        start_at(0, 1'b0, 1, 1'b1, e0);
        qa.push_back(e0 + 1);
        qa.push_back(e0 + 2);
        qa.push_back(e0 + 3);
        tick(3);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        chk_idle("continuous_abort", 0);
        tick(3);

        // Reset in the middle of a periodic count
        start_at(0, 1'b0, 8, 1'b1, e0);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        chk_idle("mid_reset", 0);
        reset_n = 1'b1;
        tick(12);
        chk_idle("mid_reset_quiet", 0);

        chk("qa_leftover", qa.size(), 0);
        chk("qb_leftover", qb.size(), 0);
        chk("qc_leftover", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_timer.md
Name: delay_timer

Overview:
- Parametrised programmable delay/interval generator; successor to the fixed 200000-cycle enable-driven delay block used by the OLED controller sequencer.
- Adds:
  - runtime-loadable delay length
  - tick prescaler
  - one-shot or periodic mode
  - retrigger and abort
  - busy and remaining-count status
- Sits between the OLED init/command FSM and the SPI path. Produces power-up, reset and refresh waits without separate fixed-count instances.

Parameters:
- CNT_W, 24, width of the delay count and of the remaining-count output.
- PRESCALE, 1, clocks per tick, >=1. A tick is one unit of the delay count.
- DEFAULT_DELAY, 200000, tick count loaded when use_default=1. Must fit in CNT_W bits.
- RETRIGGER, 1, 1 = start while running restarts the delay; 0 = start while running is ignored.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a delay; sampled each rising edge.
- use_default  input  1  at start: 1 = load DEFAULT_DELAY, 0 = load delay_value.
- delay_value  input  CNT_W  delay length in ticks; sampled only on an accepted start.
- periodic  input  1  at start: 0 = one-shot, 1 = auto-reload. Latched at start.
- abort  input  1  cancel the running delay.
- busy  output  1  high while in RUN.
- done  output  1  one-clock pulse at each expiry.
- remaining  output  CNT_W  ticks left in the current period; 0 in IDLE.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, remaining=0.
  - Prescaler cleared; latched length and mode cleared.
  - Reset mid-delay drops the delay with no done.
- Load value: L = use_default ? DEFAULT_DELAY : delay_value. L=0 is treated as 1. L is latched into len_q; periodic is latched into mode_q.
- States:
  - IDLE: start -> RUN. On that edge: remaining<=L, prescaler<=0, busy<=1.
  - RUN:
    - Prescaler counts 0..PRESCALE-1 and wraps. A tick occurs on the wrap cycle.
    - On a tick with remaining>1: remaining<=remaining-1.
    - On a tick with remaining==1 (expiry): done<=1.
      - mode_q=0: go to IDLE, busy<=0, remaining<=0.
      - mode_q=1: stay in RUN, remaining<=len_q, prescaler wraps to 0.
- Latency:
  - start accepted at edge E0 -> done is high for exactly the cycle following edge E0+L*PRESCALE.
  - busy falls on that same edge (one-shot).
  - Periodic: done pulses every L*PRESCALE clocks, with no drift.
- done is never high for two consecutive cycles unless L*PRESCALE==1 in periodic mode; in that case done is held continuously high.
- Priority within one edge: reset_n > abort > start > expiry.
- Abort:
  - In RUN: go to IDLE next edge; busy=0, remaining=0, no done, even if expiry coincides.
  - In IDLE: no effect.
  - abort and start together: abort wins; start is dropped.
- Start while RUN:
  - RETRIGGER=1: reload L and the new periodic value, prescaler<=0. This applies even on the expiry edge; there done still pulses, then the new delay runs.
  - RETRIGGER=0: start is ignored; inputs are not re-sampled.
- Arithmetic: remaining is an unsigned CNT_W-bit down-counter that never underflows. Prescaler width is clog2(PRESCALE), minimum 1 bit.
- delay_value, use_default and periodic are ignored except on an accepted start.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks with start=1 -> busy=0, done=0, remaining=0 throughout. After release, no activity until a new start pulse.
- One-shot: PRESCALE=1, delay_value=5, start at edge 10 -> remaining 5,4,3,2,1; done high in the cycle after edge 15; busy low from edge 15.
- Default and prescale: PRESCALE=4, use_default=1, DEFAULT_DELAY=3 -> done exactly 12 clocks after start; L=0 -> done exactly 4 clocks after start.
- Periodic: delay_value=4, periodic=1, PRESCALE=1 -> done pulses at start+4, +8, +12. Abort at start+10 -> busy low at start+11, no pulse at +12.
- Retrigger: RETRIGGER=1, L=10, second start at start+6 with L=3 -> single done at start+9, none at start+10. With RETRIGGER=0 -> done only at start+10.
- Collisions:
  - abort and expiry on the same edge -> no done.
  - start and expiry on the same edge (RETRIGGER=1, one-shot) -> done pulses and busy stays 1.
  - reset_n=0 mid-count -> all outputs 0 next cycle.
